cgra_launch_ctrl: RTL and testbench

Host-side launcher that drives the other end of the CGRA kernel handshake. It raises `Computation_Start` on a host launch request and holds it until `Computation_Done` is observed. It then drops Start, waits for Done to return low, and reports status and the measured kernel cycle count. It sits between the host register file and the `Computation_Start`/`Computation_Done` pins of the CGRA top.

---
 rtl/cgra_launch_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 29 ++
 rtl/cgra_launch_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_cgra_launch_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cgra_launch_pkg.sv
// rtl/cgra_launch_pkg.sv - shared types and constants for the CGRA kernel launcher
//
// Contents:
//   launch_state_e  launcher FSM states (IDLE, START, RELEASE)
//   ST_*            2-bit launch status codes reported to the host
//   SYNC_DEPTH      number of flops in the Computation_Done synchronizer
package cgra_launch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        RELEASE = 2'd2
    } launch_state_e;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_STALE   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORTED = 2'b11;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit two-flop synchronizer with async active-high reset
//
// Ports:
//   clk   destination clock
//   rst   asynchronous active-high reset, clears both flops
//   din   asynchronous input level
//   dout  synchronized level, SYNC_DEPTH cycles behind din
module sync_2ff
    import cgra_launch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [SYNC_DEPTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], din};
        end
    end

    assign dout = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/cgra_launch_ctrl.sv
// rtl/cgra_launch_ctrl.sv - host-side launcher for the CGRA Start/Done kernel handshake
//
// Optional feature: define CGRA_LAUNCH_TIMEOUT_EN to build the watchdog that
// ends a launch with status TIMEOUT after TIMEOUT_CYCLES in START or RELEASE.
//
// Ports:
//   Clk, Rst            clock, asynchronous active-high reset
//   Launch_Req, Abort   single-cycle host pulses
//   Computation_Start   kernel start level to the CGRA
//   Computation_Done    kernel done level from the CGRA (asynchronous)
//   Busy                high whenever the FSM is not IDLE
//   Done_Pulse          one-cycle pulse when a launch finishes (any status)
//   Status              result of the last launch (OK/STALE/TIMEOUT/ABORTED)
//   Overrun             sticky: launch requested while busy
//   Cycle_Count         Start-high cycles up to the synchronized Done rise, saturating
module cgra_launch_ctrl
    import cgra_launch_pkg::*;
#(
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Launch_Req,
    input  logic                 Abort,
    output logic                 Computation_Start,
    input  logic                 Computation_Done,
    output logic                 Busy,
    output logic                 Done_Pulse,
    output logic [1:0]           Status,
    output logic                 Overrun,
    output logic [CNT_WIDTH-1:0] Cycle_Count
);

    generate
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 2");
        end
    endgenerate

    launch_state_e        state_q, state_n;
    logic [1:0]           pend_q, pend_n;
    logic [1:0]           status_q, status_n;
    logic                 pulse_q, pulse_n;
    logic                 overrun_q, overrun_n;
    logic [CNT_WIDTH-1:0] count_q, count_n;
    logic [1:0]           rel_status;
    logic                 done_s;

    sync_2ff u_done_sync (
        .clk  (Clk),
        .rst  (Rst),
        .din  (Computation_Done),
        .dout (done_s)
    );

`ifdef CGRA_LAUNCH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_q, wd_n;
    logic            wd_hit;

    // The first cycle of a state sees wd_q == 0, so hitting TIMEOUT_CYCLES-1
    // means the state has lasted exactly TIMEOUT_CYCLES cycles.
    assign wd_hit = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_n = wd_q + WD_W'(1);
        if (state_q == IDLE || state_n != state_q) begin
            wd_n = '0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_n;
        end
    end
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        pend_n     = pend_q;
        status_n   = status_q;
        pulse_n    = 1'b0;
        overrun_n  = overrun_q;
        count_n    = count_q;
        // An abort seen in RELEASE overrides whatever the kernel reported.
        rel_status = Abort ? ST_ABORTED : pend_q;

        if (Launch_Req && state_q != IDLE) begin
            overrun_n = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Launch wins over a simultaneous Abort: Abort is not examined here.
                if (Launch_Req) begin
                    if (!done_s) begin
                        state_n   = START;
                        pend_n    = ST_OK;
                        status_n  = ST_OK;
                        overrun_n = 1'b0;
                        count_n   = '0;
                    end else begin
                        // Done still high from a previous kernel: refuse to start.
                        status_n = ST_STALE;
                        pulse_n  = 1'b1;
                    end
                end
            end
            START: begin
                if (count_q != '1) begin
                    count_n = count_q + CNT_WIDTH'(1);
                end
                if (Abort) begin
                    state_n = RELEASE;
                    pend_n  = ST_ABORTED;
                end else if (done_s) begin
                    state_n = RELEASE;
                    pend_n  = ST_OK;
                end
`ifdef CGRA_LAUNCH_TIMEOUT_EN
                else if (wd_hit) begin
                    state_n = RELEASE;
                    pend_n  = ST_TIMEOUT;
                end
`endif
            end
            RELEASE: begin
                pend_n = rel_status;
                if (!done_s) begin
                    state_n  = IDLE;
                    status_n = rel_status;
                    pulse_n  = 1'b1;
                end
`ifdef CGRA_LAUNCH_TIMEOUT_EN
                else if (wd_hit) begin
                    state_n  = IDLE;
                    status_n = ST_TIMEOUT;
                    pulse_n  = 1'b1;
                end
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pend_q    <= ST_OK;
            status_q  <= ST_OK;
            pulse_q   <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            pend_q    <= pend_n;
            status_q  <= status_n;
            pulse_q   <= pulse_n;
            overrun_q <= overrun_n;
            count_q   <= count_n;
        end
    end

    // Start decodes straight from the state flop so reset drops it asynchronously.
    assign Computation_Start = (state_q == START);
    assign Busy              = (state_q != IDLE);
    assign Done_Pulse        = pulse_q;
    assign Status            = status_q;
    assign Overrun           = overrun_q;
    assign Cycle_Count       = count_q;

endmodule

// File: tb/tb_cgra_launch_ctrl.sv
// tb/tb_cgra_launch_ctrl.sv - directed self-checking bench for cgra_launch_ctrl
module tb_cgra_launch_ctrl;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Launch_Req;
    logic        Abort;
    logic        Computation_Start;
    logic        Computation_Done;
    logic        Busy;
    logic        Done_Pulse;
    logic [1:0]  Status;
    logic        Overrun;
    logic [31:0] Cycle_Count;

    int total = 0;
    int bad   = 0;

    cgra_launch_ctrl #(
        .CNT_WIDTH      (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .Clk               (Clk),
        .Rst               (Rst),
        .Launch_Req        (Launch_Req),
        .Abort             (Abort),
        .Computation_Start (Computation_Start),
        .Computation_Done  (Computation_Done),
        .Busy              (Busy),
        .Done_Pulse        (Done_Pulse),
        .Status            (Status),
        .Overrun           (Overrun),
        .Cycle_Count       (Cycle_Count)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got time-limit expiry expected completion");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic launch();
        Launch_Req = 1'b1;
        step(1);
        Launch_Req = 1'b0;
    endtask

    task automatic abort_pulse();
        Abort = 1'b1;
        step(1);
        Abort = 1'b0;
    endtask

    int n;
    int pulses;

    initial begin
        Rst              = 1'b1;
        Launch_Req       = 1'b0;
        Abort            = 1'b0;
        Computation_Done = 1'b0;
        step(2);
        check("rst_start",   32'(Computation_Start), 0);
        check("rst_busy",    32'(Busy),              0);
        check("rst_pulse",   32'(Done_Pulse),        0);
        check("rst_status",  32'(Status),            0);
        check("rst_overrun", 32'(Overrun),           0);
        check("rst_count",   Cycle_Count,            0);
        Rst = 1'b0;
        step(2);

        // Normal launch: Done raised in the 10th Start-high cycle, so done_s is
        // seen in the 12th and Cycle_Count ends at 12.
        launch();
        check("n_start", 32'(Computation_Start), 1);
        check("n_busy",  32'(Busy),              1);
        step(9);
        Computation_Done = 1'b1;
        n = 0;
        while (Computation_Start && n < 50) begin
            step(1);
            n++;
        end
        check("n_fall_lat", n, 3);
        Computation_Done = 1'b0;
        check("n_count", Cycle_Count, 12);
        check("n_pulse_early", 32'(Done_Pulse), 0);
        step(3);
        check("n_pulse",  32'(Done_Pulse), 1);
        check("n_status", 32'(Status),     0);
        check("n_busy_after", 32'(Busy),   0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            pulses += int'(Done_Pulse);
        end
        check("n_single_pulse", pulses, 0);

        // Stale Done: Done already high when the launch arrives.
        Computation_Done = 1'b1;
        step(3);
        launch();
        check("s_pulse",  32'(Done_Pulse),        1);
        check("s_status", 32'(Status),            1);
        check("s_start",  32'(Computation_Start), 0);
        check("s_busy",   32'(Busy),              0);
        check("s_count_hold", Cycle_Count,        12);
        step(1);
        check("s_pulse_end", 32'(Done_Pulse), 0);
        Computation_Done = 1'b0;
        step(4);

        // Abort 5 cycles into START with Done never raised.
        launch();
        check("a_start",        32'(Computation_Start), 1);
        check("a_status_clear", 32'(Status),            0);
        step(4);
        abort_pulse();
        check("a_start_fall", 32'(Computation_Start), 0);
        check("a_count",      Cycle_Count,            5);
        step(1);
        check("a_pulse",  32'(Done_Pulse), 1);
        check("a_status", 32'(Status),     3);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            pulses += int'(Done_Pulse);
        end
        check("a_single_pulse", pulses, 0);

        // Overrun: second launch during START is dropped and flagged.
        launch();
        step(1);
        launch();
        check("o_flag",  32'(Overrun),           1);
        check("o_start", 32'(Computation_Start), 1);
        check("o_count", Cycle_Count,            2);
        abort_pulse();
        step(4);
        check("o_no_restart", 32'(Computation_Start), 0);
        check("o_sticky",     32'(Overrun),           1);

        // Next accepted launch clears Overrun; Done is never raised (timeout case).
        launch();
        check("o_clear",  32'(Overrun),           0);
        check("t_start",  32'(Computation_Start), 1);
`ifdef CGRA_LAUNCH_TIMEOUT_EN
        n = 0;
        while (Computation_Start && n < 100) begin
            step(1);
            n++;
        end
        check("t_start_len", n, 16);
        step(1);
        check("t_pulse",  32'(Done_Pulse), 1);
        check("t_status", 32'(Status),     2);
`else
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            n += int'(Computation_Start);
            step(1);
        end
        check("t_hold_1000", n, 1000);
        abort_pulse();
        step(1);
        check("t_abort_status", 32'(Status), 3);
`endif
        step(3);

        // Reset in START with Overrun set: everything returns to reset values at once.
        launch();
        step(1);
        launch();
        check("r_pre_overrun", 32'(Overrun), 1);
        #2;
        Rst = 1'b1;
        #1;
        check("r_start",   32'(Computation_Start), 0);
        check("r_busy",    32'(Busy),              0);
        check("r_pulse",   32'(Done_Pulse),        0);
        check("r_status",  32'(Status),            0);
        check("r_overrun", 32'(Overrun),           0);
        check("r_count",   Cycle_Count,            0);
        step(1);
        Rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            pulses += int'(Done_Pulse) + int'(Busy);
        end
        check("r_quiet", pulses, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
